// File: rtl/idex_operand_stage_if.sv
// Bundles the decode-side request, the forwarding sources and the execute-side
// outputs of the ID/EX operand stage.
interface idex_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    // decode side
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [5:0]       in_funct;
    logic [4:0]       in_shamt;
    logic [RA_W-1:0]  in_rs;
    logic [RA_W-1:0]  in_rt;
    logic [WIDTH-1:0] in_rs_data;
    logic [WIDTH-1:0] in_rt_data;
    logic [RA_W-1:0]  in_rd;
    logic             in_reg_write;
    // forwarding sources
    logic             exmem_reg_write;
    logic             exmem_is_load;
    logic [RA_W-1:0]  exmem_rd;
    logic [WIDTH-1:0] exmem_result;
    logic             memwb_reg_write;
    logic [RA_W-1:0]  memwb_rd;
    logic [WIDTH-1:0] memwb_result;
    // execute side
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [RA_W-1:0]  dest_rd;
    logic             reg_write;
    logic [CNT_W-1:0] stall_count;

    modport slave (
        input  flush, in_valid, in_opcode, in_funct, in_shamt, in_rs, in_rt,
               in_rs_data, in_rt_data, in_rd, in_reg_write,
               exmem_reg_write, exmem_is_load, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, out_ready,
        output in_ready, out_valid, opcode, funct, shamt, op1, op2, dest_rd,
               reg_write, stall_count
    );

    modport master (
        output flush, in_valid, in_opcode, in_funct, in_shamt, in_rs, in_rt,
               in_rs_data, in_rt_data, in_rd, in_reg_write,
               exmem_reg_write, exmem_is_load, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, out_ready,
        input  in_ready, out_valid, opcode, funct, shamt, op1, op2, dest_rd,
               reg_write, stall_count
    );
endinterface

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register: captures decoded fields, forwards operands from
// EX/MEM and MEM/WB, stalls decode on load-use, and refreshes a held entry's
// operands from MEM/WB while execute is stalled.
module idex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    idex_operand_stage_if.slave  bus
);
    logic             load_use;
    logic             in_ready;
    logic             capture;
    logic [WIDTH-1:0] op1_fwd, op2_fwd;

    logic             out_valid_q;
    logic [5:0]       opcode_q, funct_q;
    logic [4:0]       shamt_q;
    logic [WIDTH-1:0] op1_q, op2_q;
    logic [RA_W-1:0]  dest_rd_q, hold_rs_q, hold_rt_q;
    logic             reg_write_q;
    logic [CNT_W-1:0] stall_q;

    // A load in EX/MEM has no result yet, so a dependent instruction must wait.
    always_comb begin
        load_use = bus.exmem_reg_write && bus.exmem_is_load && (bus.exmem_rd != '0) &&
                   ((bus.exmem_rd == bus.in_rs) || (bus.exmem_rd == bus.in_rt));
        in_ready = (!out_valid_q || bus.out_ready) && !load_use && !bus.flush;
        capture  = bus.in_valid && in_ready;
    end

    // Operand forwarding: r0 is always zero, the younger EX/MEM result beats MEM/WB.
    always_comb begin
        op1_fwd = bus.in_rs_data;
        op2_fwd = bus.in_rt_data;
        if (bus.in_rs == '0)
            op1_fwd = '0;
        else if (bus.exmem_reg_write && !bus.exmem_is_load && bus.exmem_rd == bus.in_rs)
            op1_fwd = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd == bus.in_rs)
            op1_fwd = bus.memwb_result;
        if (bus.in_rt == '0)
            op2_fwd = '0;
        else if (bus.exmem_reg_write && !bus.exmem_is_load && bus.exmem_rd == bus.in_rt)
            op2_fwd = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd == bus.in_rt)
            op2_fwd = bus.memwb_result;
    end

    // Entry register: flush beats capture, capture beats consume; a held entry
    // snoops MEM/WB so a producer retiring during the stall is not missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            funct_q     <= '0;
            shamt_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            dest_rd_q   <= '0;
            reg_write_q <= 1'b0;
            hold_rs_q   <= '0;
            hold_rt_q   <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            opcode_q    <= bus.in_opcode;
            funct_q     <= bus.in_funct;
            shamt_q     <= bus.in_shamt;
            op1_q       <= op1_fwd;
            op2_q       <= op2_fwd;
            dest_rd_q   <= bus.in_rd;
            reg_write_q <= bus.in_reg_write;
            hold_rs_q   <= bus.in_rs;
            hold_rt_q   <= bus.in_rt;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end else if (out_valid_q) begin
            if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == hold_rs_q)
                op1_q <= bus.memwb_result;
            if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == hold_rt_q)
                op2_q <= bus.memwb_result;
        end
    end

    // Saturating count of cycles decode is blocked by a load-use hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (bus.in_valid && load_use && !bus.flush && stall_q != '1)
            stall_q <= stall_q + 1'b1;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.opcode      = opcode_q;
    assign bus.funct       = funct_q;
    assign bus.shamt       = shamt_q;
    assign bus.op1         = op1_q;
    assign bus.op2         = op2_q;
    assign bus.dest_rd     = dest_rd_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: forwarding priority, r0, load-use
// stall, hold-time snooping, flush, back-to-back issue and async reset.
module tb_idex_operand_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    idex_operand_stage_if #(.WIDTH(32), .RA_W(5), .CNT_W(16)) bus ();

    idex_operand_stage #(.WIDTH(32), .RA_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [4:0] rd);
        bus.in_valid     = 1'b1;
        bus.in_opcode    = opc;
        bus.in_funct     = 6'h20;
        bus.in_shamt     = 5'd2;
        bus.in_rs        = rs;
        bus.in_rt        = rt;
        bus.in_rs_data   = rsd;
        bus.in_rt_data   = rtd;
        bus.in_rd        = rd;
        bus.in_reg_write = 1'b1;
    endtask

    task automatic exmem(input logic rw, input logic ld, input logic [4:0] rd, input logic [31:0] r);
        bus.exmem_reg_write = rw;
        bus.exmem_is_load   = ld;
        bus.exmem_rd        = rd;
        bus.exmem_result    = r;
    endtask

    task automatic memwb(input logic rw, input logic [4:0] rd, input logic [31:0] r);
        bus.memwb_reg_write = rw;
        bus.memwb_rd        = rd;
        bus.memwb_result    = r;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        instr(6'h00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0);
        bus.in_valid = 1'b0;
        exmem(1'b0, 1'b0, 5'd0, 32'h0);
        memwb(1'b0, 5'd0, 32'h0);

        // reset state
        #12;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_op1", bus.op1, 32'h0);
        chk("rst_opcode", {26'b0, bus.opcode}, 32'h0);
        chk("rst_stall", {16'b0, bus.stall_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // EX/MEM beats MEM/WB for rs=3; rt=5 falls through to register file
        instr(6'h08, 5'd3, 5'd5, 32'h100, 32'h200, 5'd9);
        exmem(1'b1, 1'b0, 5'd3, 32'h11);
        memwb(1'b1, 5'd3, 32'h22);
        #1;
        chk("a_in_ready", {31'b0, bus.in_ready}, 32'h1);
        tick();
        chk("a_out_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("a_op1_exmem", bus.op1, 32'h11);
        chk("a_op2_rf", bus.op2, 32'h200);
        chk("a_dest_rd", {27'b0, bus.dest_rd}, 32'd9);
        chk("a_opcode", {26'b0, bus.opcode}, 32'h08);

        // r0 reads zero despite EX/MEM writing rd=0; rt=5 from MEM/WB; back-to-back issue
        instr(6'h0A, 5'd0, 5'd5, 32'h5555, 32'h200, 5'd6);
        exmem(1'b1, 1'b0, 5'd0, 32'hFF);
        memwb(1'b1, 5'd5, 32'h33);
        tick();
        chk("b_out_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("b_opcode", {26'b0, bus.opcode}, 32'h0A);
        chk("b_op1_r0", bus.op1, 32'h0);
        chk("b_op2_memwb", bus.op2, 32'h33);

        // load-use on rt=4: one stalled cycle, then capture with MEM/WB value
        instr(6'h0B, 5'd1, 5'd4, 32'h1111, 32'h9999, 5'd7);
        exmem(1'b1, 1'b1, 5'd4, 32'hDEAD);
        memwb(1'b0, 5'd0, 32'h0);
        #1;
        chk("c_in_ready_stall", {31'b0, bus.in_ready}, 32'h0);
        tick();
        chk("c_stall_count", {16'b0, bus.stall_count}, 32'd1);
        chk("c_out_valid_bubble", {31'b0, bus.out_valid}, 32'h0);
        exmem(1'b0, 1'b0, 5'd0, 32'h0);
        memwb(1'b1, 5'd4, 32'h4444);
        #1;
        chk("c_in_ready_go", {31'b0, bus.in_ready}, 32'h1);
        tick();
        chk("c_out_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("c_op2_memwb", bus.op2, 32'h4444);
        chk("c_op1_rf", bus.op1, 32'h1111);
        chk("c_stall_hold", {16'b0, bus.stall_count}, 32'd1);

        // hold with rt=7 while MEM/WB retires r7
        instr(6'h0C, 5'd2, 5'd7, 32'h22, 32'h77, 5'd8);
        memwb(1'b0, 5'd0, 32'h0);
        tick();
        chk("d_op2_capture", bus.op2, 32'h77);
        bus.out_ready = 1'b0;
        instr(6'h0E, 5'd9, 5'd10, 32'h1, 32'h2, 5'd11);
        memwb(1'b1, 5'd7, 32'hABCD);
        #1;
        chk("d_in_ready_hold", {31'b0, bus.in_ready}, 32'h0);
        tick();
        chk("d_op2_snoop", bus.op2, 32'hABCD);
        chk("d_op1_kept", bus.op1, 32'h22);
        chk("d_opcode_frozen", {26'b0, bus.opcode}, 32'h0C);
        chk("d_out_valid", {31'b0, bus.out_valid}, 32'h1);

        // flush with held entry and incoming instruction
        memwb(1'b0, 5'd0, 32'h0);
        bus.flush = 1'b1;
        #1;
        chk("e_in_ready_flush", {31'b0, bus.in_ready}, 32'h0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("e_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("e_no_capture", {26'b0, bus.opcode}, 32'h0C);

        // async reset while holding a valid entry
        instr(6'h0D, 5'd3, 5'd4, 32'h3333, 32'h4444, 5'd5);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("f_out_valid_pre", {31'b0, bus.out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("f_rst_op1", bus.op1, 32'h0);
        chk("f_rst_op2", bus.op2, 32'h0);
        chk("f_rst_stall", {16'b0, bus.stall_count}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
